// File: rtl/ana_modul.sv
// ana_modul: one registered AES-128 encryption round plus the matching
// key-expansion step. Ten instances chained with j = 0..9 form a 10-cycle
// encryption pipeline that accepts one block per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; clears both outputs
//   anahtar      [127:0] round key K(j) (cipher key for j = 0)
//   j            [3:0]   round index 0..9, static (tied at instantiation)
//   blok         [127:0] state in (plaintext for j = 0)
//   sifre        [127:0] registered round output state
//   turAnahtari  [127:0] registered next round key K(j+1)
//
// Byte 0 sits in bits [127:120]. The state is column-major, so byte 4c+r is
// row r, column c.
module ana_modul (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [3:0]   j,
  input  logic [127:0] blok,
  output logic [127:0] sifre,
  output logic [127:0] turAnahtari
);

  // Element 0 is the most significant byte, which matches the byte numbering.
  typedef logic [0:15][7:0] state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: {a0,a1,a2,a3} with a0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3),
            (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] sifre_d, sifre_q;
  logic [127:0] tur_anahtari_d, tur_anahtari_q;
  logic [31:0]  rot_w, t_w, n0, n1, n2, n3;
  state_t       ark, sb, sr, mc, rnd;

  // Key expansion: next round key K(j+1) from K(j).
  always_comb begin
    rot_w = {anahtar[23:0], anahtar[31:24]};
    t_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
            ^ {rcon(j), 24'h0};
    n0    = anahtar[127:96] ^ t_w;
    n1    = anahtar[95:64]  ^ n0;
    n2    = anahtar[63:32]  ^ n1;
    n3    = anahtar[31:0]   ^ n2;
    tur_anahtari_d = {n0, n1, n2, n3};
  end

  // Round datapath. Only stage 0 performs the initial AddRoundKey; the last
  // stage (j == 9) skips MixColumns.
  always_comb begin
    ark = (j == 4'd0) ? (blok ^ anahtar) : blok;
    sb  = '0;
    sr  = '0;
    mc  = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(ark[i]);
    // ShiftRows: row r rotates left by r, so column c takes column (c+r)%4.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
        mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    rnd     = (j == 4'd9) ? sr : mc;
    sifre_d = rnd ^ tur_anahtari_d;
  end

  // Key and data are registered together so chained stages stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sifre_q        <= '0;
      tur_anahtari_q <= '0;
    end else begin
      sifre_q        <= sifre_d;
      tur_anahtari_q <= tur_anahtari_d;
    end
  end

  assign sifre       = sifre_q;
  assign turAnahtari = tur_anahtari_q;

endmodule

// File: tb/tb_ana_modul.sv
// Directed bench for ana_modul: a single stage with a bench-driven round
// index, plus a ten-stage chain forming a full AES-128 encryptor.
module tb_ana_modul;

  logic clk;
  logic rst;

  // Single stage
  logic [127:0] u_key, u_blk, u_sifre, u_tur;
  logic [3:0]   u_j;

  ana_modul u_dut (
    .clk(clk), .rst(rst), .anahtar(u_key), .j(u_j), .blok(u_blk),
    .sifre(u_sifre), .turAnahtari(u_tur)
  );

  // Ten-stage chain
  logic [127:0] c_pt, c_key;
  logic [127:0] ch_s [0:10];
  logic [127:0] ch_k [0:10];

  assign ch_s[0] = c_pt;
  assign ch_k[0] = c_key;

  for (genvar g = 0; g < 10; g++) begin : g_chain
    ana_modul u_st (
      .clk(clk), .rst(rst), .anahtar(ch_k[g]), .j(4'(g)), .blok(ch_s[g]),
      .sifre(ch_s[g+1]), .turAnahtari(ch_k[g+1])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] IDLE_P = 128'hdeadbeef0badf00d1234567876543210;
  localparam logic [127:0] IDLE_K = 128'hfedcba98765432100123456789abcdef;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    u_j   = 4'd0;
    u_key = 128'hcafef00dcafef00dcafef00dcafef00d;
    u_blk = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    c_pt  = IDLE_P;
    c_key = IDLE_K;

    // Reset held for two edges with arbitrary inputs
    step();
    step();
    chk("rst_sifre", u_sifre, 128'h0);
    chk("rst_tur", u_tur, 128'h0);
    chk("rst_chain_s9", ch_s[10], 128'h0);
    chk("rst_chain_k9", ch_k[10], 128'h0);

    // j=0 round with C.1 vectors
    rst   = 1'b0;
    u_key = KEY_C1;
    u_blk = PT_C1;
    step();
    chk("c1_r1_sifre", u_sifre, 128'h89d810e8855ace682d1843d8cb128fe4);
    chk("c1_r1_key", u_tur, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    // j=0 key step with the A.1 key
    u_key = KEY_B;
    step();
    chk("a1_key1", u_tur, 128'ha0fafe1788542cb123a339392a6c7605);

    // j=9 final round (no MixColumns)
    u_j   = 4'd9;
    u_key = 128'hac7766f319fadc2128d12941575c006e;
    u_blk = 128'heb40f21e592e38848ba113e71bc342d2;
    step();
    chk("j9_sifre", u_sifre, CT_B);
    chk("j9_key", u_tur, K10_B);

    // Out-of-range index: Rcon is zero
    u_j   = 4'd10;
    u_key = 128'h0;
    u_blk = 128'h0;
    step();
    chk("j10_key", u_tur, 128'h63636363636363636363636363636363);
    chk("j10_sifre", u_sifre, 128'h0);

    // Zero key at j=0: Rcon 01 lands in the top byte
    u_j = 4'd0;
    step();
    chk("j0_zero_key", u_tur, 128'h62636363626363636263636362636363);

    // Ten-stage chain: three blocks back-to-back
    c_pt  = PT_C1;
    c_key = KEY_C1;
    for (int k = 1; k <= 12; k++) begin
      step();
      case (k)
        1: begin c_pt = PT_B;   c_key = KEY_B;  end
        2: begin c_pt = 128'h0; c_key = 128'h0; end
        3: begin c_pt = IDLE_P; c_key = IDLE_K; end
        default: ;
      endcase
      if (k == 9) begin
        checks++;
        assert (ch_s[10] !== CT_C1) else begin
          failures++;
          $error("FAIL chain_early: got %h one cycle before expected %h", ch_s[10], CT_C1);
        end
      end
      if (k == 10) begin
        chk("chain_ct_a", ch_s[10], CT_C1);
        chk("chain_k10_a", ch_k[10], K10_C1);
      end
      if (k == 11) begin
        chk("chain_ct_b", ch_s[10], CT_B);
        chk("chain_k10_b", ch_k[10], K10_B);
      end
      if (k == 12) chk("chain_ct_z", ch_s[10], CT_Z);
    end

    // Fill the chain with C.1 blocks, then reset mid-stream
    c_pt  = PT_C1;
    c_key = KEY_C1;
    for (int k = 0; k < 10; k++) step();
    chk("full_ct", ch_s[10], CT_C1);
    rst = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("mid_rst_s%0d", i - 1), ch_s[i], 128'h0);
      chk($sformatf("mid_rst_k%0d", i - 1), ch_k[i], 128'h0);
    end
    rst = 1'b0;
    step();
    chk("refill_s0", ch_s[1], 128'h89d810e8855ace682d1843d8cb128fe4);
    for (int k = 2; k <= 10; k++) step();
    chk("refill_ct", ch_s[10], CT_C1);
    chk("refill_k10", ch_k[10], K10_C1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
